uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers. It accepts one byte at a time from a requester and holds it stable on the transmitter data input. It pulses the transmitter start, then waits for the transmitter done pulse before granting the next requester. A watchdog recovers the scheduler if the transmitter never signals done.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART transmit arbiter.
// The slave side is the arbiter; the master side is requesters plus transmitter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         tx_start;
   logic [DATA_BITS-1:0]         tx_data;
   logic                         tx_done;
   logic                         busy;
   logic [$clog2(NUM_REQ)-1:0]   grant_id;
   logic                         tx_timeout;

   modport master (
      output req_valid, req_data, tx_done,
      input  req_ready, tx_start, tx_data, busy, grant_id, tx_timeout
   );

   modport slave (
      input  req_valid, req_data, tx_done,
      output req_ready, tx_start, tx_data, busy, grant_id, tx_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ producers,
// with a watchdog that recovers from a transmitter that never reports done.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic             clk,
   input  logic             reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [GW:0]   NR     = (GW+1)'(NUM_REQ);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [GW-1:0]        last_q, last_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic [WW-1:0]        wd_q, wd_d;
   logic                 to_q, to_d;

   logic                 hit;
   logic [GW-1:0]        win;
   logic [GW:0]          cand;

   // Scan starting just after the last winner so it ends up lowest priority.
   always_comb begin
      hit  = 1'b0;
      win  = '0;
      cand = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_q} + (GW+1)'(k);
         if (cand >= NR) cand = cand - NR;
         if (!hit && bus.req_valid[cand[GW-1:0]]) begin
            hit = 1'b1;
            win = cand[GW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      data_d  = data_q;
      ready_d = '0;
      wd_d    = wd_q;
      to_d    = to_q;
      unique case (state_q)
         S_IDLE: begin
            if (hit) begin
               data_d  = bus.req_data[win*DATA_BITS +: DATA_BITS];
               grant_d = win;
               last_d  = win;
               ready_d = NUM_REQ'(1) << win;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done takes precedence over a simultaneous watchdog expiry.
            if (bus.tx_done) begin
               state_d = S_IDLE;
            end else if (wd_q == WD_MAX) begin
               to_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= GW'(NUM_REQ - 1);
         grant_q <= '0;
         data_q  <= '0;
         ready_q <= '0;
         wd_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         wd_q    <= wd_d;
         to_q    <= to_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.tx_start   = (state_q == S_LAUNCH);
   assign bus.tx_data    = data_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.grant_id   = grant_q;
   assign bus.tx_timeout = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued at stimulus
// time and retired whenever the arbiter pulses tx_start.
module tb_uart_tx_arbiter;
   localparam int TO = 64;

   typedef struct {
      logic [1:0] g;
      logic [7:0] d;
   } exp_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   exp_t q[$];

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(4),
      .DATA_BITS(8),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [7:0] b);
      bus.req_data[i*8 +: 8] = b;
   endtask

   task automatic push(input logic [1:0] g, input logic [7:0] d);
      exp_t e;
      e.g = g;
      e.d = d;
      q.push_back(e);
   endtask

   task automatic wait_start();
      for (int i = 0; i < 50; i++) begin
         if (bus.tx_start === 1'b1) return;
         tick();
      end
      chk("start_wait_expired", 0, 1);
   endtask

   task automatic pulse_done(input int n);
      repeat (n) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
   endtask

   // Retire one expected grant per start pulse; req_ready must be idle otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (bus.tx_start === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               e = q.pop_front();
               chk("tx_data", 32'(bus.tx_data), 32'(e.d));
               chk("grant_id", 32'(bus.grant_id), 32'(e.g));
               chk("req_ready", 32'(bus.req_ready), 32'(4'b0001 << e.g));
               chk("busy_launch", 32'(bus.busy), 1);
            end
         end else begin
            chk("ready_idle", 32'(bus.req_ready), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int n;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_done   = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_start", 32'(bus.tx_start), 0);
      chk("rst_data", 32'(bus.tx_data), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_grant", 32'(bus.grant_id), 0);
      chk("rst_timeout", 32'(bus.tx_timeout), 0);
      reset = 1'b0;
      tick();

      // All four continuously valid: 0,1,2,3,0
      set_req(0, 8'h10);
      set_req(1, 8'h21);
      set_req(2, 8'h32);
      set_req(3, 8'h43);
      push(0, 8'h10);
      push(1, 8'h21);
      push(2, 8'h32);
      push(3, 8'h43);
      push(0, 8'h10);
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_start();
         if (k == 4) bus.req_valid = '0;
         pulse_done(3);
      end
      chk("rr_idle", 32'(bus.busy), 0);

      // Single request, long transmission
      set_req(0, 8'hA5);
      push(0, 8'hA5);
      bus.req_valid = 4'b0001;
      tick();
      chk("single_start", 32'(bus.tx_start), 1);
      chk("single_ready", 32'(bus.req_ready), 4'b0001);
      bus.req_valid = '0;
      repeat (39) tick();
      chk("single_hold", 32'(bus.tx_data), 8'hA5);
      chk("single_busy", 32'(bus.busy), 1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("single_done_idle", 32'(bus.busy), 0);

      // Back-to-back: next start exactly 2 cycles after done
      set_req(2, 8'h77);
      push(2, 8'h77);
      bus.req_valid = 4'b0100;
      wait_start();
      bus.req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_hold", 32'(bus.tx_data), 8'h77);
      end
      set_req(1, 8'h5A);
      push(1, 8'h5A);
      bus.req_valid = 4'b0010;
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("b2b_gap1", 32'(bus.tx_start), 0);
      tick();
      chk("b2b_gap2", 32'(bus.tx_start), 1);
      bus.req_valid = '0;
      pulse_done(4);

      // Watchdog expiry
      set_req(3, 8'h99);
      push(3, 8'h99);
      bus.req_valid = 4'b1000;
      wait_start();
      bus.req_valid = '0;
      tick();
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      chk("wait_len", n, TO);
      chk("timeout_set", 32'(bus.tx_timeout), 1);
      set_req(0, 8'h3C);
      push(0, 8'h3C);
      bus.req_valid = 4'b0001;
      wait_start();
      bus.req_valid = '0;
      pulse_done(2);
      chk("after_to_idle", 32'(bus.busy), 0);
      chk("timeout_sticky", 32'(bus.tx_timeout), 1);

      // Done on the expiry cycle: no timeout
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_timeout", 32'(bus.tx_timeout), 0);
      set_req(1, 8'hC3);
      push(1, 8'hC3);
      bus.req_valid = 4'b0010;
      wait_start();
      bus.req_valid = '0;
      tick();
      repeat (TO - 1) tick();
      chk("collide_busy", 32'(bus.busy), 1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("collide_idle", 32'(bus.busy), 0);
      chk("collide_no_to", 32'(bus.tx_timeout), 0);

      // Async reset mid-WAIT
      set_req(2, 8'hE7);
      push(2, 8'hE7);
      bus.req_valid = 4'b0100;
      wait_start();
      bus.req_valid = '0;
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_start", 32'(bus.tx_start), 0);
      chk("arst_ready", 32'(bus.req_ready), 0);
      chk("arst_data", 32'(bus.tx_data), 0);
      chk("arst_grant", 32'(bus.grant_id), 0);
      tick();
      reset = 1'b0;
      set_req(0, 8'h11);
      set_req(2, 8'h22);
      set_req(3, 8'h33);
      push(0, 8'h11);
      bus.req_valid = 4'b1101;
      wait_start();
      bus.req_valid = '0;
      pulse_done(2);
      chk("final_idle", 32'(bus.busy), 0);
      chk("queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
